// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// tqvp_dlmiles_i2c_pkg: command, error and state encodings for the I2C bit engine
package tqvp_dlmiles_i2c_pkg;
  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ARB     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;
  typedef enum logic [3:0] {
    IDLE, STA_SU, STA_HD, STA_LOW, RS_LOW, RS_RISE, BIT_LOW,
    BIT_RISE, BIT_HIGH, BIT_FALL, STO_LOW, STO_RISE, STO_SU, STO_BUF
  } state_e;
endpackage

// File: rtl/tqvp_dlmiles_i2c_bit_engine.sv
// tqvp_dlmiles_i2c_bit_engine: I2C master bit engine (START/rSTART/STOP/bit) driving open-drain enables
module tqvp_dlmiles_i2c_bit_engine
  import tqvp_dlmiles_i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       cmd_bit_i,
  output logic       rsp_valid_o,
  output logic       rsp_bit_o,
  output logic [1:0] rsp_err_o,
  output logic       bus_held_o,
  output logic       timer_run_o,
  output logic       timer_restart_o,
  input  logic       stb_edgewait_i,
  input  logic       stb_prewait_i,
  input  logic       stb_scllow_i,
  input  logic       stb_sclhigh_i,
  input  logic       stb_overflow_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);
  state_e state, state_n;
  logic scl_n, sda_n, held_n, rbit_n, done, arb1_q, go, accept;
  logic [1:0] fail;
  // timer strobes are stale in the cycle the timer is being restarted
  assign go = !timer_restart_o;
  assign cmd_ready_o = state == IDLE;
  assign timer_run_o = state != IDLE;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = done || fail != ERR_OK;
  assign rsp_err_o = fail;
  always_comb begin
    state_n = state;
    done = 1'b0;
    fail = ERR_OK;
    rbit_n = rsp_bit_o;
    case (state)
      IDLE: if (accept) begin
        if (cmd_i == CMD_START) begin
          state_n = bus_held_o ? RS_LOW : (scl_i && sda_i) ? STA_SU : IDLE;
          fail = (bus_held_o || (scl_i && sda_i)) ? ERR_OK : ERR_ARB;
        end else if (cmd_i == CMD_STOP) begin
          state_n = bus_held_o ? STO_LOW : IDLE;
          done = !bus_held_o;
        end else state_n = BIT_LOW;
      end
      STA_SU:  if (go && stb_prewait_i) state_n = STA_HD;
      STA_HD:  if (go && stb_prewait_i) state_n = STA_LOW;
      STA_LOW: if (go && stb_edgewait_i) begin state_n = IDLE; done = 1'b1; end
      RS_LOW:  if (go && stb_scllow_i) state_n = RS_RISE;
      BIT_LOW: if (go && stb_scllow_i) state_n = BIT_RISE;
      STO_LOW: if (go && stb_scllow_i) state_n = STO_RISE;
      RS_RISE, BIT_RISE, STO_RISE:
        if (scl_i) state_n = state == RS_RISE ? STA_SU : state == BIT_RISE ? BIT_HIGH : STO_SU;
        else if (go && stb_overflow_i) fail = ERR_TIMEOUT;
      BIT_HIGH: if (go && stb_sclhigh_i) begin
        rbit_n = sda_i;
        state_n = BIT_FALL;
        if (arb1_q && !sda_i) fail = ERR_ARB;
      end
      BIT_FALL: if (go && stb_edgewait_i) begin state_n = IDLE; done = 1'b1; end
      STO_SU:   if (go && stb_prewait_i) state_n = STO_BUF;
      STO_BUF:  if (go && stb_prewait_i) begin state_n = IDLE; done = 1'b1; end
      default:  state_n = IDLE;
    endcase
    scl_n = scl_oe_o;
    sda_n = sda_oe_o;
    held_n = (done && state == STA_LOW) || (bus_held_o && !(done && state == STO_BUF));
    // line enables are a function of the phase being entered
    if (state_n != state)
      case (state_n)
        STA_HD:           sda_n = 1'b1;
        STA_LOW, STO_LOW: begin scl_n = 1'b1; sda_n = 1'b1; end
        RS_LOW:           begin scl_n = 1'b1; sda_n = 1'b0; end
        BIT_LOW:          begin scl_n = 1'b1; sda_n = cmd_i == CMD_WRITE && !cmd_bit_i; end
        RS_RISE, BIT_RISE, STO_RISE: scl_n = 1'b0;
        BIT_FALL:         scl_n = 1'b1;
        STO_BUF:          sda_n = 1'b0;
        default:          ;
      endcase
    if (fail != ERR_OK) begin
      state_n = IDLE;
      scl_n = 1'b0;
      sda_n = 1'b0;
      held_n = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      scl_oe_o <= 1'b0;
      sda_oe_o <= 1'b0;
      bus_held_o <= 1'b0;
      rsp_bit_o <= 1'b0;
      arb1_q <= 1'b0;
      timer_restart_o <= 1'b0;
    end else begin
      state <= state_n;
      scl_oe_o <= scl_n;
      sda_oe_o <= sda_n;
      bus_held_o <= held_n;
      rsp_bit_o <= rbit_n;
      if (accept) arb1_q <= cmd_i == CMD_WRITE && cmd_bit_i;
      timer_restart_o <= state_n != state && state_n != IDLE;
    end
endmodule

// File: tb/tb_tqvp_dlmiles_i2c_bit_engine.sv
// tb_tqvp_dlmiles_i2c_bit_engine: scoreboard bench with an ideal phase timer and wired-AND bus model
module tb_tqvp_dlmiles_i2c_bit_engine;
  localparam logic [1:0] C_START = 2'b00, C_STOP = 2'b01, C_WRITE = 2'b10, C_READ = 2'b11;
  localparam logic [1:0] E_OK = 2'b00, E_ARB = 2'b01, E_TO = 2'b10;
  localparam logic [11:0] T_EDGE = 12'd2, T_PRE = 12'd3, T_LOW = 12'd4, T_HIGH = 12'd4, T_OVF = 12'd511;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_bit_i = 1'b0;
  logic [1:0] cmd_i = 2'b00;
  logic cmd_ready_o, rsp_valid_o, rsp_bit_o, bus_held_o, timer_run_o, timer_restart_o;
  logic [1:0] rsp_err_o;
  logic stb_edgewait_i, stb_prewait_i, stb_scllow_i, stb_sclhigh_i, stb_overflow_i;
  logic scl_oe_o, sda_oe_o;
  logic scl_s = 1'b1, scl_i = 1'b1, sda_s = 1'b1, sda_i = 1'b1;
  logic dev_scl_low = 1'b0, dev_sda_low = 1'b0;
  logic scl_bus, sda_bus, scl_prev = 1'b1, sda_prev = 1'b1;
  logic [11:0] tcnt = 12'd0;
  logic [3:0] sb_q[$];
  int checks = 0, errors = 0, rsp_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int n, sda_hi, held_lo, s0;

  tqvp_dlmiles_i2c_bit_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i), .cmd_bit_i(cmd_bit_i),
    .rsp_valid_o(rsp_valid_o), .rsp_bit_o(rsp_bit_o), .rsp_err_o(rsp_err_o),
    .bus_held_o(bus_held_o), .timer_run_o(timer_run_o), .timer_restart_o(timer_restart_o),
    .stb_edgewait_i(stb_edgewait_i), .stb_prewait_i(stb_prewait_i), .stb_scllow_i(stb_scllow_i),
    .stb_sclhigh_i(stb_sclhigh_i), .stb_overflow_i(stb_overflow_i),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    tcnt <= (!rst_n || timer_restart_o) ? 12'd0 : timer_run_o ? tcnt + 12'd1 : tcnt;
  assign stb_edgewait_i = tcnt == T_EDGE;
  assign stb_prewait_i = tcnt == T_PRE;
  assign stb_scllow_i = tcnt == T_LOW;
  assign stb_sclhigh_i = tcnt >= T_HIGH;
  assign stb_overflow_i = tcnt >= T_OVF;

  assign scl_bus = !(scl_oe_o || dev_scl_low);
  assign sda_bus = !(sda_oe_o || dev_sda_low);
  always @(posedge clk) begin
    scl_s <= scl_bus; scl_i <= scl_s;
    sda_s <= sda_bus; sda_i <= sda_s;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (scl_prev && scl_bus && sda_prev && !sda_bus) start_cnt++;
    if (scl_prev && scl_bus && !sda_prev && sda_bus) stop_cnt++;
    scl_prev <= scl_bus;
    sda_prev <= sda_bus;
  end

  always @(negedge clk) begin
    logic [3:0] x;
    if (rst_n && rsp_valid_o) begin
      if (sb_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        x = sb_q.pop_front();
        check("rsp_err", int'(rsp_err_o), int'(x[1:0]));
        if (x[3]) check("rsp_bit", int'(rsp_bit_o), int'(x[2]));
      end
      rsp_cnt++;
    end
  end

  task automatic issue(input logic [1:0] c, input logic b, input logic [1:0] e, input logic ck,
                       input logic eb, output int cyc, output int shi, output int hlo);
    int r0;
    r0 = rsp_cnt;
    sb_q.push_back({ck, eb, e});
    cmd_valid_i = 1'b1; cmd_i = c; cmd_bit_i = b;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cyc = 0; shi = 0; hlo = 0;
    while (rsp_cnt == r0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      shi += int'(sda_oe_o);
      hlo += int'(!bus_held_o);
    end
    if (rsp_cnt == r0) check("rsp_wait_expired", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    check("rst_scl_oe", int'(scl_oe_o), 0);
    check("rst_sda_oe", int'(sda_oe_o), 0);
    check("rst_ready", int'(cmd_ready_o), 1);
    check("rst_rsp_valid", int'(rsp_valid_o), 0);
    check("rst_held", int'(bus_held_o), 0);
    check("rst_run", int'(timer_run_o), 0);
    check("rst_restart", int'(timer_restart_o), 0);
    rst_n = 1'b1;
    idle(3);
    // START then STOP on a free bus
    issue(C_START, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("start_held", int'(bus_held_o), 1);
    check("start_edge", start_cnt, 1);
    issue(C_STOP, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("stop_held", int'(bus_held_o), 0);
    check("stop_edge", stop_cnt, 1);
    check("stop_lines", int'(scl_oe_o || sda_oe_o), 0);
    // STOP on an idle bus completes in the acceptance cycle
    issue(C_STOP, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("stop_idle_lat", n, 0);
    // START with SDA already low loses arbitration at once
    dev_sda_low = 1'b1;
    idle(3);
    issue(C_START, 1'b0, E_ARB, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("start_busy_lat", n, 0);
    check("start_busy_held", int'(bus_held_o), 0);
    dev_sda_low = 1'b0;
    idle(3);
    // plain writes
    issue(C_START, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    issue(C_WRITE, 1'b0, E_OK, 1'b1, 1'b0, n, sda_hi, held_lo);
    issue(C_WRITE, 1'b1, E_OK, 1'b1, 1'b1, n, sda_hi, held_lo);
    // write 1 against a device holding SDA low
    dev_sda_low = 1'b1;
    issue(C_WRITE, 1'b1, E_ARB, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("arb_scl_oe", int'(scl_oe_o), 0);
    check("arb_sda_oe", int'(sda_oe_o), 0);
    check("arb_held", int'(bus_held_o), 0);
    dev_sda_low = 1'b0;
    idle(3);
    // read with the device driving 0
    issue(C_START, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    dev_sda_low = 1'b1;
    issue(C_READ, 1'b1, E_OK, 1'b1, 1'b0, n, sda_hi, held_lo);
    check("read_sda_oe", sda_hi, 0);
    dev_sda_low = 1'b0;
    // repeated START keeps the bus held
    s0 = start_cnt;
    issue(C_START, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("rstart_edge", start_cnt - s0, 1);
    check("rstart_held_lo", held_lo, 0);
    check("rstart_held", int'(bus_held_o), 1);
    // slave stretches SCL for 100 cycles after release
    dev_scl_low = 1'b1;
    fork
      begin
        for (int k = 0; k < 3000 && scl_oe_o; k++) @(posedge clk);
        repeat (100) @(posedge clk);
        dev_scl_low = 1'b0;
      end
    join_none
    issue(C_WRITE, 1'b0, E_OK, 1'b1, 1'b0, n, sda_hi, held_lo);
    check("stretch_len", int'(n > 100), 1);
    check("stretch_held", int'(bus_held_o), 1);
    // SCL held low forever
    dev_scl_low = 1'b1;
    issue(C_WRITE, 1'b1, E_TO, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("to_len", int'(n > 511), 1);
    check("to_held", int'(bus_held_o), 0);
    check("to_lines", int'(scl_oe_o || sda_oe_o), 0);
    dev_scl_low = 1'b0;
    idle(3);
    // reset while the engine sits in BIT_HIGH
    issue(C_START, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    cmd_valid_i = 1'b1; cmd_i = C_READ; cmd_bit_i = 1'b0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 200 && scl_oe_o; k++) @(negedge clk);
    for (int k = 0; k < 200 && !scl_i; k++) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_scl_oe", int'(scl_oe_o), 0);
    check("mid_rst_sda_oe", int'(sda_oe_o), 0);
    check("mid_rst_held", int'(bus_held_o), 0);
    check("mid_rst_ready", int'(cmd_ready_o), 1);
    check("mid_rst_run", int'(timer_run_o), 0);
    check("mid_rst_err", int'(rsp_err_o), 0);
    check("mid_rst_bit", int'(rsp_bit_o), 0);
    rst_n = 1'b1;
    idle(3);
    issue(C_STOP, 1'b0, E_OK, 1'b0, 1'b0, n, sda_hi, held_lo);
    check("post_rst_stop_lat", n, 0);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
